// File: rtl/regfile_wb_port.sv
// regfile_wb_port -- 31 x 32-bit general-purpose register file with one
// writeback write port, two operand read ports and one debug read port.
//
// Index 0 is hard-wired to zero on every read port and writes to it are
// dropped. Reads are combinational (zero-cycle latency). wrcount counts
// committed writes and saturates at 16'hFFFF.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   : a same-cycle write to the index read on port A or B is
//               forwarded to that port (write-before-read).
//   undefined : ports A and B return stored contents only; the pipeline's
//               forwarding unit resolves the same-cycle hazard.
//   dbgdata always reflects storage and is never forwarded.
//
// Ports:
//   clk           in   1  rising-edge clock
//   rstn          in   1  asynchronous active-low reset
//   weregfile     in   1  writeback write enable
//   wraddr        in   5  writeback destination index
//   datatoregfile in  32  writeback data
//   rdaddra       in   5  port A read index (rs)
//   rdaddrb       in   5  port B read index (rt)
//   dataa         out 32  port A read data
//   datab         out 32  port B read data
//   dbgaddr       in   5  debug read index
//   dbgdata       out 32  debug read data (storage only)
//   wrcount       out 16  saturating count of committed writes
module regfile_wb_port (
    input  logic        clk,
    input  logic        rstn,
    input  logic        weregfile,
    input  logic [4:0]  wraddr,
    input  logic [31:0] datatoregfile,
    input  logic [4:0]  rdaddra,
    input  logic [4:0]  rdaddrb,
    output logic [31:0] dataa,
    output logic [31:0] datab,
    input  logic [4:0]  dbgaddr,
    output logic [31:0] dbgdata,
    output logic [15:0] wrcount
);

    // Storage for indices 1..31; index 0 has no storage.
    logic [31:0] regs_r [1:31];
    logic [15:0] wrcount_r;
    logic        commit_s;
    logic [31:0] stored_a_s;
    logic [31:0] stored_b_s;
    logic [31:0] stored_dbg_s;
    logic        bypass_a_s;
    logic        bypass_b_s;

    // A write only counts when it targets a real register.
    assign commit_s = weregfile && (wraddr != 5'd0);

    // Register array: async clear, commit on rising edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 1; i < 32; i++) begin
                regs_r[i] <= 32'h0000_0000;
            end
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (commit_s && (wraddr == 5'(i))) begin
                    regs_r[i] <= datatoregfile;
                end
            end
        end
    end

    // Saturating committed-write counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wrcount_r <= 16'h0000;
        end else if (commit_s && (wrcount_r != 16'hFFFF)) begin
            wrcount_r <= wrcount_r + 16'd1;
        end else begin
            wrcount_r <= wrcount_r;
        end
    end

    // Storage lookup for all three read ports; unmatched index (0) reads zero.
    always_comb begin
        stored_a_s   = 32'h0000_0000;
        stored_b_s   = 32'h0000_0000;
        stored_dbg_s = 32'h0000_0000;
        for (int i = 1; i < 32; i++) begin
            if (rdaddra == 5'(i)) begin
                stored_a_s = regs_r[i];
            end else begin
                stored_a_s = stored_a_s;
            end
            if (rdaddrb == 5'(i)) begin
                stored_b_s = regs_r[i];
            end else begin
                stored_b_s = stored_b_s;
            end
            if (dbgaddr == 5'(i)) begin
                stored_dbg_s = regs_r[i];
            end else begin
                stored_dbg_s = stored_dbg_s;
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Forwarding is gated by rstn so every port still reads zero during reset.
    assign bypass_a_s = rstn && commit_s && (wraddr == rdaddra);
    assign bypass_b_s = rstn && commit_s && (wraddr == rdaddrb);
`else
    assign bypass_a_s = 1'b0;
    assign bypass_b_s = 1'b0;
`endif

    // Output select: forwarded write data or stored value.
    always_comb begin
        dataa = stored_a_s;
        datab = stored_b_s;
        if (bypass_a_s) begin
            dataa = datatoregfile;
        end else begin
            dataa = stored_a_s;
        end
        if (bypass_b_s) begin
            datab = datatoregfile;
        end else begin
            datab = stored_b_s;
        end
    end

    assign dbgdata = stored_dbg_s;
    assign wrcount = wrcount_r;

endmodule

// File: tb/tb_regfile_wb_port.sv
// Testbench for regfile_wb_port: reset sweep, table-driven read/write
// vectors, mid-cycle reset sequence and write-counter saturation.
// Expectations adapt to REGFILE_BYPASS_EN when the bench is built with it.
module tb_regfile_wb_port;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rstn;
    logic        weregfile;
    logic [4:0]  wraddr;
    logic [31:0] datatoregfile;
    logic [4:0]  rdaddra;
    logic [4:0]  rdaddrb;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic [4:0]  dbgaddr;
    logic [31:0] dbgdata;
    logic [15:0] wrcount;

    int tests;
    int fails;

    regfile_wb_port dut (
        .clk           (clk),
        .rstn          (rstn),
        .weregfile     (weregfile),
        .wraddr        (wraddr),
        .datatoregfile (datatoregfile),
        .rdaddra       (rdaddra),
        .rdaddrb       (rdaddrb),
        .dataa         (dataa),
        .datab         (datab),
        .dbgaddr       (dbgaddr),
        .dbgdata       (dbgdata),
        .wrcount       (wrcount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  dbg;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [31:0] ed;
        logic [15:0] ec;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] dbg,
                                input logic [31:0] ea, input logic [31:0] eb,
                                input logic [31:0] ed, input logic [15:0] ec);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.ra = ra; v.rb = rb; v.dbg = dbg;
        v.ea = ea; v.eb = eb; v.ed = ed; v.ec = ec;
        return v;
    endfunction

    initial begin
        tests = 0;
        fails = 0;

        // Expected outputs are those seen before the vector's clock edge.
        vecs[0] = mk(1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  5'd5,
                     BYP ? 32'hDEADBEEF : 32'h0, 32'h0, 32'h0, 16'd0);
        vecs[1] = mk(1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  5'd5,
                     32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 16'd1);
        vecs[2] = mk(1'b1, 5'd0,  32'h12345678, 5'd0,  5'd0,  5'd0,
                     32'h0, 32'h0, 32'h0, 16'd1);
        vecs[3] = mk(1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  5'd0,
                     32'h0, 32'h0, 32'h0, 16'd1);
        vecs[4] = mk(1'b1, 5'd7,  32'h00000001, 5'd5,  5'd7,  5'd7,
                     32'hDEADBEEF, BYP ? 32'h1 : 32'h0, 32'h0, 16'd1);
        vecs[5] = mk(1'b1, 5'd7,  32'h00000002, 5'd7,  5'd7,  5'd7,
                     BYP ? 32'h2 : 32'h1, BYP ? 32'h2 : 32'h1, 32'h1, 16'd2);
        vecs[6] = mk(1'b1, 5'd31, 32'hCAFEF00D, 5'd7,  5'd31, 5'd31,
                     32'h2, BYP ? 32'hCAFEF00D : 32'h0, 32'h0, 16'd3);
        vecs[7] = mk(1'b1, 5'd1,  32'h11111111, 5'd31, 5'd1,  5'd1,
                     32'hCAFEF00D, BYP ? 32'h11111111 : 32'h0, 32'h0, 16'd4);
        vecs[8] = mk(1'b0, 5'd1,  32'hFFFFFFFF, 5'd1,  5'd31, 5'd7,
                     32'h11111111, 32'hCAFEF00D, 32'h2, 16'd5);
        vecs[9] = mk(1'b0, 5'd0,  32'h0,        5'd1,  5'd1,  5'd1,
                     32'h11111111, 32'h11111111, 32'h11111111, 16'd5);

        rstn          = 1'b0;
        weregfile     = 1'b0;
        wraddr        = 5'd0;
        datatoregfile = 32'h0;
        rdaddra       = 5'd0;
        rdaddrb       = 5'd0;
        dbgaddr       = 5'd0;
        repeat (2) @(posedge clk);
        #1;

        // Reset sweep with an active write aimed at the read index.
        for (int a = 0; a < 32; a++) begin
            weregfile     = 1'b1;
            wraddr        = 5'(a);
            datatoregfile = 32'hFFFFFFFF;
            rdaddra       = 5'(a);
            rdaddrb       = 5'(31 - a);
            dbgaddr       = 5'(a);
            #1;
            chk($sformatf("rst_a[%0d]", a), dataa, 32'h0);
            chk($sformatf("rst_b[%0d]", 31 - a), datab, 32'h0);
            chk($sformatf("rst_dbg[%0d]", a), dbgdata, 32'h0);
        end
        @(posedge clk);
        #1;
        chk("rst_wrcount", {16'h0, wrcount}, 32'h0);
        chk("rst_hold_dbg", dbgdata, 32'h0);

        weregfile = 1'b0;
        @(negedge clk);
        rstn = 1'b1;

        // Table vectors; the first write lands on the first edge after reset.
        for (int i = 0; i < 10; i++) begin
            weregfile     = vecs[i].we;
            wraddr        = vecs[i].wa;
            datatoregfile = vecs[i].wd;
            rdaddra       = vecs[i].ra;
            rdaddrb       = vecs[i].rb;
            dbgaddr       = vecs[i].dbg;
            #1;
            chk($sformatf("v%0d_dataa", i), dataa, vecs[i].ea);
            chk($sformatf("v%0d_datab", i), datab, vecs[i].eb);
            chk($sformatf("v%0d_dbg", i), dbgdata, vecs[i].ed);
            chk($sformatf("v%0d_wrcount", i), {16'h0, wrcount}, {16'h0, vecs[i].ec});
            @(posedge clk);
            #1;
        end

        // Mid-cycle reset: write reg 3, then pull rstn low between edges.
        weregfile     = 1'b1;
        wraddr        = 5'd3;
        datatoregfile = 32'hA5A5A5A5;
        @(posedge clk);
        #1;
        weregfile = 1'b0;
        rdaddra   = 5'd3;
        rdaddrb   = 5'd31;
        dbgaddr   = 5'd3;
        #1;
        chk("mid_pre_dbg", dbgdata, 32'hA5A5A5A5);
        chk("mid_pre_cnt", {16'h0, wrcount}, 32'd6);
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_rst_a", dataa, 32'h0);
        chk("mid_rst_b", datab, 32'h0);
        chk("mid_rst_dbg", dbgdata, 32'h0);
        chk("mid_rst_cnt", {16'h0, wrcount}, 32'h0);

        // A write edge while reset is held must be discarded.
        weregfile     = 1'b1;
        wraddr        = 5'd3;
        datatoregfile = 32'h5A5A5A5A;
        @(posedge clk);
        #1;
        chk("rst_edge_dbg", dbgdata, 32'h0);
        chk("rst_edge_cnt", {16'h0, wrcount}, 32'h0);

        @(negedge clk);
        rstn          = 1'b1;
        datatoregfile = 32'h0F0F0F0F;
        @(posedge clk);
        #1;
        weregfile = 1'b0;
        #1;
        chk("first_wr_dbg", dbgdata, 32'h0F0F0F0F);
        chk("first_wr_cnt", {16'h0, wrcount}, 32'd1);

        // Saturation: 65536 more committed writes (65537 total).
        weregfile = 1'b1;
        for (int n = 0; n < 65533; n++) begin
            wraddr        = 5'((n % 31) + 1);
            datatoregfile = 32'(n);
            @(posedge clk);
            #1;
        end
        chk("sat_fffe", {16'h0, wrcount}, 32'h0000FFFE);
        wraddr        = 5'd9;
        datatoregfile = 32'h00000009;
        @(posedge clk);
        #1;
        chk("sat_ffff", {16'h0, wrcount}, 32'h0000FFFF);
        wraddr        = 5'd9;
        datatoregfile = 32'h99999999;
        @(posedge clk);
        #1;
        wraddr        = 5'd10;
        datatoregfile = 32'hAAAA5555;
        @(posedge clk);
        #1;
        weregfile = 1'b0;
        rdaddra   = 5'd9;
        rdaddrb   = 5'd10;
        dbgaddr   = 5'd0;
        #1;
        chk("sat_hold", {16'h0, wrcount}, 32'h0000FFFF);
        chk("sat_wr_a", dataa, 32'h99999999);
        chk("sat_wr_b", datab, 32'hAAAA5555);
        chk("sat_dbg0", dbgdata, 32'h0);
        @(posedge clk);
        #1;
        chk("sat_idle_hold", {16'h0, wrcount}, 32'h0000FFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
